// File: rtl/scr1_tcm_portb_ctrl.sv
// scr1_tcm_portb_ctrl: port B sequencer for the TCM dual-port RAM.
// Shares port B between the core data path (req0) and an optional
// boot/debug loader (req1). Sub-word writes run as read-modify-write
// because the RAM only takes full-word writes.
// Optional feature macro: SCR1_TCM_LOADER_EN adds the req1_* ports and
// round-robin arbitration between the two requesters.
module scr1_tcm_portb_ctrl #(
    parameter int unsigned SCR1_WIDTH  = 32,
    parameter int unsigned SCR1_SIZE   = 65536,
    parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
    localparam int unsigned AW         = $clog2(SCR1_SIZE) - 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_vld,
    input  logic                   req0_we,
    input  logic [AW-1:0]          req0_addr,
    input  logic [SCR1_NBYTES-1:0] req0_be,
    input  logic [SCR1_WIDTH-1:0]  req0_wdata,
    output logic                   req0_gnt,
    output logic                   req0_rvld,
    output logic [SCR1_WIDTH-1:0]  req0_rdata,

`ifdef SCR1_TCM_LOADER_EN
    input  logic                   req1_vld,
    input  logic                   req1_we,
    input  logic [AW-1:0]          req1_addr,
    input  logic [SCR1_NBYTES-1:0] req1_be,
    input  logic [SCR1_WIDTH-1:0]  req1_wdata,
    output logic                   req1_gnt,
    output logic                   req1_rvld,
    output logic [SCR1_WIDTH-1:0]  req1_rdata,
`endif

    output logic                   mem_renb,
    output logic                   mem_wenb,
    output logic [SCR1_NBYTES-1:0] mem_webb,
    output logic [AW-1:0]          mem_addrb,
    output logic [SCR1_WIDTH-1:0]  mem_datab,
    input  logic [SCR1_WIDTH-1:0]  mem_qb,

    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RMW_WR  = 2'd2
    } state_e;

    state_e                   state_q,     state_d;
    logic                     port_q,      port_d;
    logic [AW-1:0]            rmw_addr_q,  rmw_addr_d;
    logic [SCR1_NBYTES-1:0]   rmw_be_q,    rmw_be_d;
    logic [SCR1_WIDTH-1:0]    rmw_wdata_q, rmw_wdata_d;
`ifdef SCR1_TCM_LOADER_EN
    logic                     rr_ptr_q,    rr_ptr_d;
`endif

    // Winning request, muxed from the requesters
    logic                     sel_vld;
    logic                     sel_id;
    logic                     sel_we;
    logic [AW-1:0]            sel_addr;
    logic [SCR1_NBYTES-1:0]   sel_be;
    logic [SCR1_WIDTH-1:0]    sel_wdata;

    logic                     gnt_c;
    logic                     rvld_c;
    logic [SCR1_WIDTH-1:0]    rmw_merged;

    // The RAM cannot mask bytes, so every write is a full word
    assign mem_webb = '1;

    // Arbitration: a lone requester wins; on a tie the pointer picks the port
    // that was not granted last (pointer = port holding priority)
    always_comb begin
        sel_vld   = req0_vld;
        sel_id    = 1'b0;
        sel_we    = req0_we;
        sel_addr  = req0_addr;
        sel_be    = req0_be;
        sel_wdata = req0_wdata;
`ifdef SCR1_TCM_LOADER_EN
        sel_vld = req0_vld | req1_vld;
        if (req1_vld && (!req0_vld || rr_ptr_q)) begin
            sel_id    = 1'b1;
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_be    = req1_be;
            sel_wdata = req1_wdata;
        end
`endif
    end

    // RMW merge: enabled lanes from the latched write data, the rest from the RAM
    always_comb begin
        rmw_merged = mem_qb;
        for (int unsigned i = 0; i < SCR1_NBYTES; i++) begin
            if (rmw_be_q[i]) begin
                rmw_merged[i*8 +: 8] = rmw_wdata_q[i*8 +: 8];
            end
        end
    end

    // Next state, latched request fields and RAM port controls
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_be_d    = rmw_be_q;
        rmw_wdata_d = rmw_wdata_q;
`ifdef SCR1_TCM_LOADER_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        gnt_c       = 1'b0;
        rvld_c      = 1'b0;
        mem_renb    = 1'b0;
        mem_wenb    = 1'b0;
        mem_addrb   = '0;
        mem_datab   = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    gnt_c  = 1'b1;
                    port_d = sel_id;
`ifdef SCR1_TCM_LOADER_EN
                    rr_ptr_d = ~sel_id;
`endif
                    if (!sel_we) begin
                        mem_renb  = 1'b1;
                        mem_addrb = sel_addr;
                        state_d   = ST_RD_WAIT;
                    end else if (&sel_be) begin
                        mem_wenb  = 1'b1;
                        mem_addrb = sel_addr;
                        mem_datab = sel_wdata;
                    end else if (|sel_be) begin
                        // Partial write: fetch the old word, merge next cycle
                        mem_renb    = 1'b1;
                        mem_addrb   = sel_addr;
                        rmw_addr_d  = sel_addr;
                        rmw_be_d    = sel_be;
                        rmw_wdata_d = sel_wdata;
                        state_d     = ST_RMW_WR;
                    end
                    // be == 0: accepted with no RAM access
                end
            end
            ST_RD_WAIT: begin
                rvld_c  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RMW_WR: begin
                mem_wenb  = 1'b1;
                mem_addrb = rmw_addr_q;
                mem_datab = rmw_merged;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset cycle: silence the RAM and requesters, drop any pending RMW
        if (rst) begin
            gnt_c     = 1'b0;
            rvld_c    = 1'b0;
            mem_renb  = 1'b0;
            mem_wenb  = 1'b0;
            mem_addrb = '0;
            mem_datab = '0;
            state_d   = ST_IDLE;
        end
    end

    // Per-requester grant and read-return steering
    always_comb begin
        req0_gnt   = gnt_c & ~sel_id;
        req0_rvld  = rvld_c & ~port_q;
        req0_rdata = (rvld_c & ~port_q) ? mem_qb : '0;
`ifdef SCR1_TCM_LOADER_EN
        req1_gnt   = gnt_c & sel_id;
        req1_rvld  = rvld_c & port_q;
        req1_rdata = (rvld_c & port_q) ? mem_qb : '0;
`endif
        busy       = (state_q != ST_IDLE) & ~rst;
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            port_q      <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
`ifdef SCR1_TCM_LOADER_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_be_q    <= rmw_be_d;
            rmw_wdata_q <= rmw_wdata_d;
`ifdef SCR1_TCM_LOADER_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

endmodule
